// File: rtl/message_loader_if.sv
// Byte-stream input and message-RAM write port of the message loader.
// The producer drives the stream side through master; the loader uses slave.
interface message_loader_if #(
    parameter int unsigned MAX_MESSAGE_LENGTH = 55
);
    localparam int unsigned AW = $clog2(MAX_MESSAGE_LENGTH) + 1;

    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_last;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/message_loader.sv
// Write side of the message buffer: stores a byte stream at addresses 0.. of the message RAM,
// reports the length and holds the buffer until the hash side releases it.
module message_loader #(
    parameter int unsigned MAX_MESSAGE_LENGTH = 55,
    localparam int unsigned AW = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic              msg_release,
    message_loader_if.slave   bus,
    output logic [AW-1:0]     msg_length,
    output logic              msg_ready,
    output logic              overflow
);
    localparam logic [AW-1:0] MaxCount = AW'(MAX_MESSAGE_LENGTH);

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StDone, StError} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] msg_length_q, msg_length_d;
    logic          overflow_q, overflow_d;
    logic          msg_ready_q, msg_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          accept;

    assign bus.in_ready = (state_q == StLoad);
    assign accept       = bus.in_valid && (state_q == StLoad);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        msg_length_d = msg_length_q;
        overflow_d   = overflow_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d      = StLoad;
                    count_d      = '0;
                    msg_length_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            StLoad: begin
                if (load_start) begin
                    // Restart wins over a byte offered in the same cycle.
                    count_d      = '0;
                    msg_length_d = '0;
                end else if (accept) begin
                    if (count_q < MaxCount) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q;
                        mem_wdata_d = bus.in_data;
                        count_d     = count_q + AW'(1);
                        if (bus.in_last) begin
                            state_d      = StFlush;
                            msg_length_d = count_q + AW'(1);
                        end
                    end else begin
                        state_d    = StError;
                        overflow_d = 1'b1;
                    end
                end
            end
            StFlush: begin
                state_d = StDone;
            end
            StDone: begin
                if (msg_release) begin
                    if (load_start) begin
                        state_d      = StLoad;
                        count_d      = '0;
                        msg_length_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StError: begin
                if (load_start) begin
                    state_d      = StLoad;
                    count_d      = '0;
                    msg_length_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Registered so the reader sees msg_ready only after the last write has landed.
        msg_ready_d = (state_q == StDone) && !msg_release;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            count_q      <= '0;
            msg_length_q <= '0;
            overflow_q   <= 1'b0;
            msg_ready_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            msg_length_q <= msg_length_d;
            overflow_q   <= overflow_d;
            msg_ready_q  <= msg_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign msg_length    = msg_length_q;
    assign msg_ready     = msg_ready_q;
    assign overflow      = overflow_q;
endmodule
